// File: rtl/addtree_pkg.sv
// rtl/addtree_pkg.sv - shared widths and types for the pipelined adder tree
package addtree_pkg;

  // Largest supported tree depth (N up to 32) and tag width.
  localparam int MAX_LVL  = 5;
  localparam int MAX_TAGW = 16;

  typedef logic [MAX_TAGW-1:0] tag_t;
  typedef logic [MAX_LVL-1:0]  lvl_valid_t;

  // Width of the final sum: one bit of growth per level plus one for negation.
  function automatic int outw(input int width, input int n);
    return width + $clog2(n) + 1;
  endfunction

  // Width of each sum registered at tree level k (k = 1 is the first adder level).
  function automatic int lvlw(input int width, input int k);
    return width + k + 1;
  endfunction

endpackage

// File: rtl/addtree_level.sv
// rtl/addtree_level.sv - one registered level of the adder tree
module addtree_level #(
  parameter int WIDTH_IN = 9,
  parameter int NIN      = 8,
  parameter int TAGW     = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              in_valid,
  input  logic [NIN*WIDTH_IN-1:0]           in_data,
  input  logic [TAGW-1:0]                   in_tag,
  output logic                              out_valid,
  output logic [(NIN/2)*(WIDTH_IN+1)-1:0]   out_data,
  output logic [TAGW-1:0]                   out_tag
);

  localparam int NOUT = NIN / 2;
  localparam int WO   = WIDTH_IN + 1;

  logic [NOUT*WO-1:0] sum_d;
  logic [NOUT*WO-1:0] sum_q;
  logic               valid_q;
  logic [TAGW-1:0]    tag_q;

  // Pairwise sums; each operand is sign-extended by one bit so no carry is lost.
  always_comb begin
    sum_d = '0;
    for (int j = 0; j < NOUT; j++) begin
      sum_d[j*WO +: WO] =
          {in_data[(2*j+1)*WIDTH_IN-1], in_data[(2*j)*WIDTH_IN +: WIDTH_IN]}
        + {in_data[(2*j+2)*WIDTH_IN-1], in_data[(2*j+1)*WIDTH_IN +: WIDTH_IN]};
    end
  end

  // Level register: loads from the level below whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      tag_q   <= '0;
    end else if (en) begin
      valid_q <= in_valid;
      sum_q   <= sum_d;
      tag_q   <= in_tag;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = sum_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/addtree_pipe.sv
// rtl/addtree_pipe.sv - pipelined N-operand adder tree with per-operand negate
module addtree_pipe
  import addtree_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int N      = 8,
  parameter bit SIGNED = 1'b1,
  parameter int TAGW   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*WIDTH-1:0]         in_ops,
  input  logic [N-1:0]               in_sub,
  input  logic [TAGW-1:0]            in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [outw(WIDTH, N)-1:0]  out_sum,
  output logic [TAGW-1:0]            out_tag
);

  localparam int LVL = $clog2(N);
  localparam int PW  = WIDTH + 1;

  logic            adv;
  logic [N*PW-1:0] prep_d;
  logic [PW-1:0]   ext_d;

  // The whole tree moves together: it only stalls when a result is stuck at the output.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Operand prep: widen by one bit so negating the most negative value is exact.
  always_comb begin
    prep_d = '0;
    ext_d  = '0;
    for (int i = 0; i < N; i++) begin
      ext_d = {(SIGNED ? in_ops[i*WIDTH+WIDTH-1] : 1'b0), in_ops[i*WIDTH +: WIDTH]};
      prep_d[i*PW +: PW] = in_sub[i] ? (-ext_d) : ext_d;
    end
  end

  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int WI = lvlw(WIDTH, k);
    localparam int NI = N >> k;

    logic                        src_valid;
    logic [NI*WI-1:0]            src_data;
    logic [TAGW-1:0]             src_tag;
    logic                        vld;
    logic [(NI/2)*(WI+1)-1:0]    sum;
    logic [TAGW-1:0]             tag;

    if (k == 0) begin : g_src
      assign src_valid = in_valid;
      assign src_data  = prep_d;
      assign src_tag   = in_tag;
    end else begin : g_src
      assign src_valid = g_lvl[k-1].vld;
      assign src_data  = g_lvl[k-1].sum;
      assign src_tag   = g_lvl[k-1].tag;
    end

    addtree_level #(
      .WIDTH_IN (WI),
      .NIN      (NI),
      .TAGW     (TAGW)
    ) u_level (
      .clk       (clk),
      .reset     (reset),
      .en        (adv),
      .in_valid  (src_valid),
      .in_data   (src_data),
      .in_tag    (src_tag),
      .out_valid (vld),
      .out_data  (sum),
      .out_tag   (tag)
    );
  end

  assign out_valid = g_lvl[LVL-1].vld;
  assign out_sum   = g_lvl[LVL-1].sum;
  assign out_tag   = g_lvl[LVL-1].tag;

endmodule

// File: tb/tb_addtree_pipe.sv
// tb/tb_addtree_pipe.sv - self-checking bench for the pipelined adder tree
module tb_addtree_pipe;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int NA = 4;
  localparam int NB = 32;
  localparam int LA = $clog2(NA);
  localparam int LB = $clog2(NB);
  localparam int OA = W + LA + 1;
  localparam int OB = W + LB + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: N=4 signed
  logic            a_in_valid = 1'b0;
  logic            a_in_ready;
  logic [NA*W-1:0] a_in_ops = '0;
  logic [NA-1:0]   a_in_sub = '0;
  logic [TW-1:0]   a_in_tag = '0;
  logic            a_out_valid;
  logic            a_out_ready = 1'b1;
  logic [OA-1:0]   a_out_sum;
  logic [TW-1:0]   a_out_tag;

  // DUT B: N=32 unsigned
  logic            b_in_valid = 1'b0;
  logic            b_in_ready;
  logic [NB*W-1:0] b_in_ops = '0;
  logic [NB-1:0]   b_in_sub = '0;
  logic [TW-1:0]   b_in_tag = '0;
  logic            b_out_valid;
  logic            b_out_ready = 1'b1;
  logic [OB-1:0]   b_out_sum;
  logic [TW-1:0]   b_out_tag;

  addtree_pipe #(.WIDTH(W), .N(NA), .SIGNED(1'b1), .TAGW(TW)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ops(a_in_ops),
    .in_sub(a_in_sub), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_tag(a_out_tag)
  );

  addtree_pipe #(.WIDTH(W), .N(NB), .SIGNED(1'b0), .TAGW(TW)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ops(b_in_ops),
    .in_sub(b_in_sub), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_tag(b_out_tag)
  );

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer sum of the (optionally negated) operand values.
  function automatic longint model(input logic [NB*W-1:0] ops, input logic [NB-1:0] sub,
                                   input int n, input bit sgn);
    longint s = 0;
    longint v;
    logic [NB*W-1:0] t;
    for (int i = 0; i < n; i++) begin
      t = ops >> (i*W);
      v = longint'(t[W-1:0]);
      if (sgn && t[W-1]) v = v - (longint'(1) << W);
      if (sub[i]) v = -v;
      s += v;
    end
    return s;
  endfunction

  // Scoreboards
  longint qa_sum[$];
  int     qa_tag[$];
  longint qb_sum[$];
  int     qb_tag[$];
  logic          a_hold = 1'b0;
  logic [OA-1:0] a_hsum;
  logic [TW-1:0] a_htag;
  logic          b_hold = 1'b0;
  logic [OB-1:0] b_hsum;
  logic [TW-1:0] b_htag;

  always @(negedge clk) begin
    logic [NB*W-1:0] pa;
    logic [NB-1:0]   ps;
    if (reset) begin
      qa_sum.delete(); qa_tag.delete(); a_hold = 1'b0;
    end else begin
      chk("a_in_ready_rule", a_in_ready, !a_out_valid || a_out_ready);
      if (a_hold) begin
        chk("a_hold_valid", a_out_valid, 1);
        chk("a_hold_sum", $signed(a_out_sum), $signed(a_hsum));
        chk("a_hold_tag", a_out_tag, a_htag);
      end
      if (a_out_valid) begin
        if (a_out_ready) begin
          if (qa_sum.size() == 0) chk("a_out_without_input", qa_sum.size(), 1);
          else begin
            chk("a_sum", $signed(a_out_sum), qa_sum.pop_front());
            chk("a_tag", a_out_tag, qa_tag.pop_front());
          end
          a_hold = 1'b0;
        end else begin
          a_hold = 1'b1; a_hsum = a_out_sum; a_htag = a_out_tag;
        end
      end else a_hold = 1'b0;
      if (a_in_valid && a_in_ready) begin
        pa = '0; pa[NA*W-1:0] = a_in_ops;
        ps = '0; ps[NA-1:0] = a_in_sub;
        qa_sum.push_back(model(pa, ps, NA, 1'b1));
        qa_tag.push_back(int'(a_in_tag));
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      qb_sum.delete(); qb_tag.delete(); b_hold = 1'b0;
    end else begin
      chk("b_in_ready_rule", b_in_ready, !b_out_valid || b_out_ready);
      if (b_hold) begin
        chk("b_hold_valid", b_out_valid, 1);
        chk("b_hold_sum", $signed(b_out_sum), $signed(b_hsum));
        chk("b_hold_tag", b_out_tag, b_htag);
      end
      if (b_out_valid) begin
        if (b_out_ready) begin
          if (qb_sum.size() == 0) chk("b_out_without_input", qb_sum.size(), 1);
          else begin
            chk("b_sum", $signed(b_out_sum), qb_sum.pop_front());
            chk("b_tag", b_out_tag, qb_tag.pop_front());
          end
          b_hold = 1'b0;
        end else begin
          b_hold = 1'b1; b_hsum = b_out_sum; b_htag = b_out_tag;
        end
      end else b_hold = 1'b0;
      if (b_in_valid && b_in_ready) begin
        qb_sum.push_back(model(b_in_ops, b_in_sub, NB, 1'b0));
        qb_tag.push_back(int'(b_in_tag));
      end
    end
  end

  task automatic send_a(input logic [NA*W-1:0] ops, input logic [NA-1:0] sub,
                        input logic [TW-1:0] tag, input longint exp, input string name);
    chk({name, "_in_ready"}, a_in_ready, 1);
    a_in_valid = 1'b1; a_in_ops = ops; a_in_sub = sub; a_in_tag = tag;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    for (int e = 1; e < LA; e++) begin
      chk({name, "_early"}, a_out_valid, 0);
      @(posedge clk); #1;
    end
    chk({name, "_valid"}, a_out_valid, 1);
    chk({name, "_sum"}, $signed(a_out_sum), exp);
    chk({name, "_tag"}, a_out_tag, tag);
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [NB-1:0] sub, input logic [TW-1:0] tag,
                        input longint exp, input string name);
    chk({name, "_in_ready"}, b_in_ready, 1);
    b_in_valid = 1'b1; b_in_ops = '1; b_in_sub = sub; b_in_tag = tag;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int e = 1; e < LB; e++) begin
      chk({name, "_early"}, b_out_valid, 0);
      @(posedge clk); #1;
    end
    chk({name, "_valid"}, b_out_valid, 1);
    chk({name, "_sum"}, $signed(b_out_sum), exp);
    chk({name, "_tag"}, b_out_tag, tag);
    @(posedge clk); #1;
  endtask

  task automatic run_a(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_ops    = $urandom;
      case ($urandom_range(0, 7))
        0: a_in_ops = {NA{8'h80}};
        1: a_in_ops = {NA{8'h7f}};
        default: ;
      endcase
      a_in_sub    = NA'($urandom);
      a_in_tag    = TW'($urandom);
      a_out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
  endtask

  task automatic run_b(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      b_in_valid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NB*W/32; k++) b_in_ops[k*32 +: 32] = $urandom;
      case ($urandom_range(0, 7))
        0: b_in_ops = '1;
        1: b_in_ops = '0;
        default: ;
      endcase
      b_in_sub    = $urandom;
      b_in_tag    = TW'($urandom);
      b_out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
  endtask

  initial begin
    logic [OA-1:0] s_sum;
    logic [NB*W-1:0] pin_ops;

    // Pin the reference model with hand-computed sums.
    pin_ops = '0; pin_ops[NA*W-1:0] = {8'd1, 8'd7, 8'd3, 8'd10};
    chk("model_pin_mixed", model(pin_ops, 32'b1010, NA, 1'b1), 13);
    pin_ops = '0; pin_ops[NA*W-1:0] = {NA{8'h80}};
    chk("model_pin_neg", model(pin_ops, 32'b1111, NA, 1'b1), 512);
    chk("model_pin_uns", model('1, '1, NB, 1'b0), -8160);

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_sum", a_out_sum, 0);
    chk("rst_a_tag", a_out_tag, 0);
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_b_valid", b_out_valid, 0);

    // Unsigned extremes on the N=32 build
    send_b('0, 4'd3, 8160, "b_max");
    send_b('1, 4'd4, -8160, "b_negmax");

    // Signed directed cases on the N=4 build
    send_a({NA{8'd127}}, 4'b0000, 4'd5, 508, "a_maxpos");
    send_a({NA{8'h80}}, 4'b1111, 4'd2, 512, "a_negmin");
    send_a({8'd1, 8'd7, 8'd3, 8'd10}, 4'b1010, 4'd1, 13, "a_mixed");
    send_a({8'd1, 8'd7, 8'd3, 8'd10}, 4'b0101, 4'd7, -13, "a_mixed_inv");

    // Back-to-back throughput
    for (int t = 0; t < 6; t++) begin
      a_in_valid = 1'b1; a_in_ops = $urandom; a_in_sub = NA'($urandom); a_in_tag = TW'(t);
      @(posedge clk); #1;
      if (t >= 1) begin
        chk("tp_valid", a_out_valid, 1);
        chk("tp_tag", a_out_tag, t - 1);
      end
    end
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("tp_last_valid", a_out_valid, 1);
    chk("tp_last_tag", a_out_tag, 5);
    @(posedge clk); #1;

    // Backpressure with two samples in flight and a third waiting
    a_in_valid = 1'b1; a_in_ops = $urandom; a_in_tag = 4'd6;
    @(posedge clk); #1;
    a_in_ops = $urandom; a_in_tag = 4'd7; a_out_ready = 1'b0;
    @(posedge clk); #1;
    a_in_ops = $urandom; a_in_tag = 4'd8;
    s_sum = a_out_sum;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", a_out_valid, 1);
      chk("bp_tag", a_out_tag, 6);
      chk("bp_sum", $signed(a_out_sum), $signed(s_sum));
      chk("bp_in_ready", a_in_ready, 0);
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    chk("bp_rel_tag7", a_out_tag, 7);
    @(posedge clk); #1;
    chk("bp_rel_valid8", a_out_valid, 1);
    chk("bp_rel_tag8", a_out_tag, 8);
    @(posedge clk); #1;
    chk("bp_drained", a_out_valid, 0);

    // Reset with samples in flight
    a_in_valid = 1'b1; a_in_ops = $urandom; a_in_tag = 4'd9;
    @(posedge clk); #1;
    a_in_tag = 4'd10;
    @(posedge clk); #1;
    reset = 1'b1; a_in_tag = 4'd11;
    @(posedge clk); #1;
    chk("mrst_valid", a_out_valid, 0);
    chk("mrst_sum", a_out_sum, 0);
    chk("mrst_tag", a_out_tag, 0);
    reset = 1'b0; a_in_valid = 1'b0;
    chk("mrst_in_ready", a_in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_stale", a_out_valid, 0);
    end

    // Random traffic on both builds
    fork
      run_a(5000);
      run_b(5000);
    join

    repeat (20) @(posedge clk);
    #1;
    chk("a_drain_empty", qa_sum.size(), 0);
    chk("b_drain_empty", qb_sum.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
